calc_sequencer: RTL and testbench

Sequencer between the on-screen keypad cursor and the calculator ALU. It takes each confirmed key selection, a 5-bit key code from the cursor grid plus a one-cycle `select` pulse, and builds operand A, the operator and operand B in hex or decimal entry mode. It then launches the ALU with a start/done handshake, guards it with a timeout and presents the value for the display. It also drives the cursor's `restriction` input so that decimal mode blocks keys A–F.

---
 rtl/calc_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_calc_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// calc_sequencer: builds A, operator, B from keypad selections,
// launches the ALU, guards it with a timeout and drives the display.
// Ports: clk, rst (async active-low); select/val key strobe and code;
//   mode_dec (1=decimal entry); alu_done/alu_result from the ALU;
//   restriction (registered mode, blocks A-F); op_a/op_b/alu_op/
//   alu_start to the ALU; display_value, phase, err for the display.
module calc_sequencer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        select,
  input  logic [4:0]  val,
  input  logic        mode_dec,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        restriction,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  output logic [15:0] display_value,
  output logic [1:0]  phase,
  output logic        err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    OPA  = 2'd0,
    OPB  = 2'd1,
    EXEC = 2'd2,
    SHOW = 2'd3
  } phase_t;

  phase_t         ph_q, ph_d;
  logic [15:0]    a_q, a_d;
  logic [15:0]    b_q, b_d;
  logic [2:0]     na_q, na_d;
  logic [2:0]     nb_q, nb_d;
  logic [2:0]     op_q, op_d;
  logic           start_q, start_d;
  logic [15:0]    disp_q, disp_d;
  logic           err_q, err_d;
  logic [TW-1:0]  tmr_q, tmr_d;
  logic [TW-1:0]  tmr_inc;
  logic           mode_q;
  logic           mode_p;

  logic           key_ok;
  logic           is_dig;
  logic           is_op;
  logic           is_exe;
  logic           is_ce;
  logic           is_clr;
  logic           clr;
  logic [2:0]     op_code;
  logic [3:0]     dig;
  logic [15:0]    a_dig;
  logic [15:0]    b_dig;

  assign dig     = val[3:0];
  // codes 0x18-0x1F are dead keys
  assign key_ok  = select & ~(val[4] & val[3]);
  // decimal mode drops digits 0xA-0xF
  assign is_dig  = key_ok & ~val[4]
                 & ~(mode_q & val[3] & (val[2] | val[1]));
  assign a_dig   = mode_q ? (a_q * 16'd10 + {12'd0, dig})
                          : {a_q[11:0], dig};
  assign b_dig   = mode_q ? (b_q * 16'd10 + {12'd0, dig})
                          : {b_q[11:0], dig};
  assign tmr_inc = tmr_q + TW'(1);
  // a mode flip seen last cycle acts as CLR now
  assign clr     = (is_clr) | (mode_q ^ mode_p);

  always_comb begin
    is_op   = 1'b0;
    is_exe  = 1'b0;
    is_ce   = 1'b0;
    is_clr  = 1'b0;
    op_code = 3'd0;
    if (key_ok && val[4]) begin
      unique case (val[2:0])
        3'd0: begin is_op = 1'b1; op_code = 3'd0; end
        3'd1: begin is_op = 1'b1; op_code = 3'd2; end
        3'd2: begin is_op = 1'b1; op_code = 3'd3; end
        3'd3: is_exe = 1'b1;
        3'd4: begin is_op = 1'b1; op_code = 3'd1; end
        3'd5: begin is_op = 1'b1; op_code = 3'd4; end
        3'd6: is_ce = 1'b1;
        3'd7: is_clr = 1'b1;
      endcase
    end
  end

  always_comb begin
    ph_d    = ph_q;
    a_d     = a_q;
    b_d     = b_q;
    na_d    = na_q;
    nb_d    = nb_q;
    op_d    = op_q;
    start_d = 1'b0;
    disp_d  = disp_q;
    err_d   = err_q;
    tmr_d   = tmr_q;
    if (clr) begin
      ph_d   = OPA;
      a_d    = '0;
      b_d    = '0;
      na_d   = '0;
      nb_d   = '0;
      op_d   = '0;
      disp_d = '0;
      err_d  = 1'b0;
      tmr_d  = '0;
    end else begin
      unique case (ph_q)
        OPA: begin
          unique case (1'b1)
            is_dig: begin
              if (na_q < 3'd4) begin
                a_d  = a_dig;
                na_d = na_q + 3'd1;
              end
            end
            is_op: begin
              op_d = op_code;
              ph_d = OPB;
              b_d  = '0;
              nb_d = '0;
            end
            is_ce: begin
              a_d  = '0;
              na_d = '0;
            end
            default: ;
          endcase
        end
        OPB: begin
          unique case (1'b1)
            is_dig: begin
              if (nb_q < 3'd4) begin
                b_d  = b_dig;
                nb_d = nb_q + 3'd1;
              end
            end
            is_op: begin
              if (nb_q == 3'd0) op_d = op_code;
            end
            is_exe: begin
              start_d = 1'b1;
              tmr_d   = '0;
              ph_d    = EXEC;
            end
            is_ce: begin
              b_d  = '0;
              nb_d = '0;
            end
            default: ;
          endcase
        end
        EXEC: begin
          if (alu_done) begin
            disp_d = alu_result;
            ph_d   = SHOW;
          end else if (tmr_inc == TW'(TIMEOUT)) begin
            err_d  = 1'b1;
            disp_d = '0;
            ph_d   = SHOW;
          end else begin
            tmr_d = tmr_inc;
          end
        end
        SHOW: begin
          unique case (1'b1)
            is_dig: begin
              err_d = 1'b0;
              a_d   = {12'd0, dig};
              na_d  = 3'd1;
              ph_d  = OPA;
            end
            is_op: begin
              err_d = 1'b0;
              a_d   = disp_q;
              op_d  = op_code;
              b_d   = '0;
              nb_d  = '0;
              ph_d  = OPB;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
    // entry phases show the operand under edit
    if (ph_d == OPA)      disp_d = a_d;
    else if (ph_d == OPB) disp_d = b_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph_q    <= OPA;
      a_q     <= '0;
      b_q     <= '0;
      na_q    <= '0;
      nb_q    <= '0;
      op_q    <= '0;
      start_q <= 1'b0;
      disp_q  <= '0;
      err_q   <= 1'b0;
      tmr_q   <= '0;
      mode_q  <= 1'b0;
      mode_p  <= 1'b0;
    end else begin
      ph_q    <= ph_d;
      a_q     <= a_d;
      b_q     <= b_d;
      na_q    <= na_d;
      nb_q    <= nb_d;
      op_q    <= op_d;
      start_q <= start_d;
      disp_q  <= disp_d;
      err_q   <= err_d;
      tmr_q   <= tmr_d;
      mode_q  <= mode_dec;
      mode_p  <= mode_q;
    end
  end

  assign restriction   = mode_q;
  assign op_a          = a_q;
  assign op_b          = b_q;
  assign alu_op        = op_q;
  assign alu_start     = start_q;
  assign display_value = disp_q;
  assign phase         = ph_q;
  assign err           = err_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: table vectors, directed corner sequences and
// random keys against a behavioural model of the sequencer.
module tb_calc_sequencer;

  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        select = 1'b0;
  logic [4:0]  val = '0;
  logic        mode_dec = 1'b0;
  logic        alu_done = 1'b0;
  logic [15:0] alu_result = '0;
  logic        restriction;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic [15:0] display_value;
  logic [1:0]  phase;
  logic        err;

  calc_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .select(select),
    .val(val),
    .mode_dec(mode_dec),
    .alu_done(alu_done),
    .alu_result(alu_result),
    .restriction(restriction),
    .op_a(op_a),
    .op_b(op_b),
    .alu_op(alu_op),
    .alu_start(alu_start),
    .display_value(display_value),
    .phase(phase),
    .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          s;
    logic [4:0]  v;
    bit          md;
    bit          dn;
    logic [15:0] res;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    bit          st;
    logic [15:0] disp;
    logic [1:0]  ph;
    bit          er;
    bit          r;
  } vec_t;

  vec_t tbl[$];

  // behavioural model state
  int m_ph, m_a, m_b, m_na, m_nb, m_op, m_start;
  int m_disp, m_err, m_mode, m_pend, m_cyc;

  function automatic logic [55:0] dut_vec();
    return {restriction, op_a, op_b, alu_op, alu_start,
            display_value, phase, err};
  endfunction

  function automatic logic [55:0] mdl_vec();
    return {1'(m_mode), 16'(m_a), 16'(m_b), 3'(m_op), 1'(m_start),
            16'(m_disp), 2'(m_ph), 1'(m_err)};
  endfunction

  task automatic chk(input string nm, input logic [55:0] exp);
    logic [55:0] got;
    got = dut_vec();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  function automatic int opc(input int v);
    case (v)
      16: return 0;
      17: return 2;
      18: return 3;
      20: return 1;
      21: return 4;
      default: return -1;
    endcase
  endfunction

  function automatic int ent(input int x, input int d, input bit dec);
    if (dec) return (x * 10 + d) % 65536;
    return (x * 16 + d) % 65536;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_a = 0; m_b = 0; m_na = 0; m_nb = 0; m_op = 0;
    m_start = 0; m_disp = 0; m_err = 0; m_mode = 0; m_pend = 0;
    m_cyc = 0;
  endtask

  task automatic model_step(input bit s, input int v, input bit md,
                            input bit dn, input int res);
    bit key, clr, dig, old;
    int o;
    old = m_mode[0];
    key = s && v < 24;
    clr = (key && v == 23) || (m_pend != 0);
    dig = key && v < 16 && !(old && v > 9);
    o = key ? opc(v) : -1;
    m_start = 0;
    if (clr) begin
      m_ph = 0; m_a = 0; m_b = 0; m_na = 0; m_nb = 0; m_op = 0;
      m_disp = 0; m_err = 0; m_cyc = 0;
    end else begin
      case (m_ph)
        0: begin
          if (dig) begin
            if (m_na < 4) begin m_a = ent(m_a, v, old); m_na++; end
          end else if (o >= 0) begin
            m_op = o; m_ph = 1; m_b = 0; m_nb = 0;
          end else if (key && v == 22) begin
            m_a = 0; m_na = 0;
          end
        end
        1: begin
          if (dig) begin
            if (m_nb < 4) begin m_b = ent(m_b, v, old); m_nb++; end
          end else if (o >= 0) begin
            if (m_nb == 0) m_op = o;
          end else if (key && v == 19) begin
            m_start = 1; m_cyc = 0; m_ph = 2;
          end else if (key && v == 22) begin
            m_b = 0; m_nb = 0;
          end
        end
        2: begin
          if (dn) begin
            m_disp = res; m_ph = 3;
          end else begin
            m_cyc++;
            if (m_cyc == TIMEOUT) begin
              m_err = 1; m_disp = 0; m_ph = 3;
            end
          end
        end
        default: begin
          if (dig) begin
            m_err = 0; m_a = v; m_na = 1; m_ph = 0;
          end else if (o >= 0) begin
            m_err = 0; m_a = m_disp; m_op = o;
            m_b = 0; m_nb = 0; m_ph = 1;
          end
        end
      endcase
    end
    if (m_ph == 0) m_disp = m_a;
    else if (m_ph == 1) m_disp = m_b;
    m_pend = (md != old) ? 1 : 0;
    m_mode = md;
  endtask

  task automatic step(input bit s, input int v, input bit md,
                      input bit dn, input int res, input string nm);
    select = s;
    val = 5'(v);
    mode_dec = md;
    alu_done = dn;
    alu_result = 16'(res);
    model_step(s, v, md, dn, res);
    @(posedge clk);
    #1;
    chk(nm, mdl_vec());
  endtask

  task automatic do_reset();
    select = 1'b0;
    alu_done = 1'b0;
    mode_dec = 1'b0;
    rst = 1'b0;
    #1;
    chk("async_reset", 56'd0);
    model_reset();
    @(posedge clk);
    #1;
    chk("reset_hold", 56'd0);
    rst = 1'b1;
  endtask

  task automatic add(input bit s, input int v, input bit md,
                     input bit dn, input int res, input int a,
                     input int b, input int op, input bit st,
                     input int disp, input int ph, input bit r);
    vec_t t;
    t.s = s; t.v = 5'(v); t.md = md; t.dn = dn; t.res = 16'(res);
    t.a = 16'(a); t.b = 16'(b); t.op = 3'(op); t.st = st;
    t.disp = 16'(disp); t.ph = 2'(ph); t.er = 1'b0; t.r = r;
    tbl.push_back(t);
  endtask

  initial begin
    bit md;
    int v;

    // hex add, then chaining / operator replace
    add(1, 'h01, 0, 0, 0,     'h0001, 0, 0, 0, 'h0001, 0, 0);
    add(1, 'h02, 0, 0, 0,     'h0012, 0, 0, 0, 'h0012, 0, 0);
    add(1, 'h10, 0, 0, 0,     'h0012, 0, 0, 0, 'h0000, 1, 0);
    add(1, 'h03, 0, 0, 0,     'h0012, 3, 0, 0, 'h0003, 1, 0);
    add(1, 'h13, 0, 0, 0,     'h0012, 3, 0, 1, 'h0003, 2, 0);
    add(0, 'h00, 0, 1, 'h15,  'h0012, 3, 0, 0, 'h0015, 3, 0);
    add(1, 'h14, 0, 0, 0,     'h0015, 0, 1, 0, 'h0000, 1, 0);
    add(1, 'h12, 0, 0, 0,     'h0015, 0, 3, 0, 'h0000, 1, 0);
    add(1, 'h05, 0, 0, 0,     'h0015, 5, 3, 0, 'h0005, 1, 0);
    add(1, 'h15, 0, 0, 0,     'h0015, 5, 3, 0, 'h0005, 1, 0);
    add(1, 'h13, 0, 0, 0,     'h0015, 5, 3, 1, 'h0005, 2, 0);
    add(0, 'h00, 0, 0, 0,     'h0015, 5, 3, 0, 'h0005, 2, 0);
    add(0, 'h00, 0, 1, 'hAAA, 'h0015, 5, 3, 0, 'h0AAA, 3, 0);
    // SHOW ignores EXE, CE, invalid; digit restarts A
    add(1, 'h13, 0, 0, 0,     'h0015, 5, 3, 0, 'h0AAA, 3, 0);
    add(1, 'h16, 0, 0, 0,     'h0015, 5, 3, 0, 'h0AAA, 3, 0);
    add(1, 'h18, 0, 0, 0,     'h0015, 5, 3, 0, 'h0AAA, 3, 0);
    add(1, 'h04, 0, 0, 0,     'h0004, 5, 3, 0, 'h0004, 0, 0);
    add(1, 'h16, 0, 0, 0,     'h0000, 5, 3, 0, 'h0000, 0, 0);
    add(1, 'h13, 0, 0, 0,     'h0000, 5, 3, 0, 'h0000, 0, 0);
    add(0, 'h00, 0, 1, 'h1234,'h0000, 5, 3, 0, 'h0000, 0, 0);
    add(1, 'h17, 0, 0, 0,     'h0000, 0, 0, 0, 'h0000, 0, 0);
    // decimal entry
    add(0, 'h00, 1, 0, 0,     'h0000, 0, 0, 0, 'h0000, 0, 1);
    add(0, 'h00, 1, 0, 0,     'h0000, 0, 0, 0, 'h0000, 0, 1);
    add(1, 'h01, 1, 0, 0,     'h0001, 0, 0, 0, 'h0001, 0, 1);
    add(1, 'h02, 1, 0, 0,     'h000C, 0, 0, 0, 'h000C, 0, 1);
    add(1, 'h05, 1, 0, 0,     'h007D, 0, 0, 0, 'h007D, 0, 1);
    add(1, 'h0B, 1, 0, 0,     'h007D, 0, 0, 0, 'h007D, 0, 1);
    add(1, 'h07, 1, 0, 0,     'h04E9, 0, 0, 0, 'h04E9, 0, 1);
    add(1, 'h03, 1, 0, 0,     'h04E9, 0, 0, 0, 'h04E9, 0, 1);
    add(1, 'h11, 1, 0, 0,     'h04E9, 0, 2, 0, 'h0000, 1, 1);
    add(1, 'h0F, 1, 0, 0,     'h04E9, 0, 2, 0, 'h0000, 1, 1);
    add(1, 'h09, 1, 0, 0,     'h04E9, 9, 2, 0, 'h0009, 1, 1);
    add(1, 'h16, 1, 0, 0,     'h04E9, 0, 2, 0, 'h0000, 1, 1);

    model_reset();
    #12;
    chk("reset_state", 56'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    foreach (tbl[i]) begin
      select = tbl[i].s;
      val = tbl[i].v;
      mode_dec = tbl[i].md;
      alu_done = tbl[i].dn;
      alu_result = tbl[i].res;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d", i),
          {tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].st,
           tbl[i].disp, tbl[i].ph, tbl[i].er});
    end

    // timeout after TIMEOUT exec cycles, then recovery by a digit
    do_reset();
    step(1, 'h01, 0, 0, 0, "to_a");
    step(1, 'h10, 0, 0, 0, "to_add");
    step(1, 'h02, 0, 0, 0, "to_b");
    step(1, 'h13, 0, 0, 0, "to_exe");
    for (int i = 0; i < TIMEOUT - 1; i++)
      step(0, 0, 0, 0, 0, "to_wait");
    chk16("to_not_yet", 16'(phase), 16'd2);
    step(0, 0, 0, 0, 0, "to_fire");
    chk16("to_err", 16'(err), 16'd1);
    chk16("to_disp", display_value, 16'd0);
    chk16("to_phase", 16'(phase), 16'd3);
    step(1, 'h04, 0, 0, 0, "to_digit");
    chk16("to_err_clr", 16'(err), 16'd0);
    chk16("to_opa", op_a, 16'h0004);
    chk16("to_phase_opa", 16'(phase), 16'd0);

    // CLR during EXEC drops a later done
    step(1, 'h10, 0, 0, 0, "ce_add");
    step(1, 'h07, 0, 0, 0, "ce_b");
    step(1, 'h13, 0, 0, 0, "ce_exe");
    step(0, 0, 0, 0, 0, "ce_idle");
    step(1, 'h17, 0, 0, 0, "ce_clr");
    step(0, 0, 0, 0, 0, "ce_w1");
    step(0, 0, 0, 0, 0, "ce_w2");
    step(0, 0, 0, 1, 'h5555, "ce_done");
    chk16("ce_phase", 16'(phase), 16'd0);
    chk16("ce_opa", op_a, 16'd0);
    chk16("ce_opb", op_b, 16'd0);
    chk16("ce_disp", display_value, 16'd0);

    // CLR and done in the same cycle
    step(1, 'h10, 0, 0, 0, "cd_add");
    step(1, 'h13, 0, 0, 0, "cd_exe");
    step(1, 'h17, 0, 1, 'h4321, "cd_both");
    chk16("cd_disp", display_value, 16'd0);

    // async reset mid-entry, then a stale done
    step(1, 'h03, 0, 0, 0, "ar_digit");
    #2;
    do_reset();
    step(0, 0, 0, 1, 'h7777, "ar_late_done");
    chk16("ar_late_disp", display_value, 16'd0);

    // mode flip clears two cycles after the edge
    step(1, 'h03, 0, 0, 0, "mc_3");
    step(1, 'h04, 0, 0, 0, "mc_4");
    chk16("mc_opa", op_a, 16'h0034);
    step(0, 0, 1, 0, 0, "mc_e1");
    chk16("mc_hold", op_a, 16'h0034);
    chk16("mc_restr", 16'(restriction), 16'd1);
    step(0, 0, 1, 0, 0, "mc_e2");
    chk16("mc_clear", op_a, 16'd0);

    // random keys against the model
    md = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) md = ~md;
      v = $urandom_range(0, 31);
      step($urandom_range(0, 1) == 1, v, md,
           (m_ph == 2) ? ($urandom_range(0, 2) == 0)
                       : ($urandom_range(0, 19) == 0),
           $urandom_range(0, 65535), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
